// File: rtl/ram8_master.sv
// rtl/ram8_master.sv - command-driven initiator for an 8x16 RAM8 memory port
module ram8_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_WAIT, S_RD_CAP, S_RESP, S_CLEAR
  } state_t;

  state_t state, state_nxt;

  // Clear sweep counter is one bit wider than the address so the 7->0 wrap
  // shows up in the top bit and ends the sweep instead of repeating it.
  logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt, clr_cnt_inc;
  logic              accept;
  logic              cmd_ready_nxt, rsp_valid_nxt, done_nxt, err_nxt, mem_load_nxt;
  logic [DATA_W-1:0] rsp_data_nxt, mem_wdata_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;

  assign accept      = cmd_valid & cmd_ready;
  assign clr_cnt_inc = clr_cnt + CNT_ONE;

  // State and registered outputs; reset drops every output immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clr_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_load  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_data  <= rsp_data_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mem_load  <= mem_load_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ:  state_nxt = S_RD_WAIT;
            OP_WRITE: state_nxt = S_WRITE;
            OP_CLEAR: state_nxt = S_CLEAR;
            default:  state_nxt = S_IDLE;
          endcase
        end
      end
      S_WRITE:   state_nxt = S_IDLE;
      S_RD_WAIT: state_nxt = S_RD_CAP;
      S_RD_CAP:  state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) state_nxt = S_IDLE;
      S_CLEAR:   if (clr_cnt_inc[ADDR_W]) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not driven holds
  always_comb begin
    cmd_ready_nxt = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    mem_load_nxt  = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    clr_cnt_nxt   = clr_cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ: mem_addr_nxt = cmd_addr;
            OP_WRITE: begin
              mem_load_nxt  = 1'b1;
              mem_addr_nxt  = cmd_addr;
              mem_wdata_nxt = cmd_wdata;
            end
            OP_CLEAR: begin
              mem_load_nxt  = 1'b1;
              mem_addr_nxt  = '0;
              mem_wdata_nxt = '0;
              clr_cnt_nxt   = '0;
            end
            default: begin
              err_nxt       = 1'b1;
              cmd_ready_nxt = 1'b1;
            end
          endcase
        end else begin
          cmd_ready_nxt = 1'b1;
        end
      end
      S_WRITE: begin
        done_nxt      = 1'b1;
        cmd_ready_nxt = 1'b1;
      end
      S_RD_CAP: begin
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = mem_rdata;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end
      S_CLEAR: begin
        clr_cnt_nxt = clr_cnt_inc;
        if (clr_cnt_inc[ADDR_W]) begin
          done_nxt      = 1'b1;
          cmd_ready_nxt = 1'b1;
        end else begin
          mem_load_nxt = 1'b1;
          mem_addr_nxt = clr_cnt_inc[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram8_master.sv
// tb/tb_ram8_master.sv - self-checking bench for ram8_master with a behavioural RAM8
module tb_ram8_master;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          done, err, mem_load;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  ram8_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .err(err),
    .mem_load(mem_load), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM8: synchronous write, registered read
  logic [DW-1:0] ram [0:7];
  always @(posedge clk) begin
    if (mem_load) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transaction-level model: memory image, expected RAM writes, expected responses
  logic [DW-1:0]    model_mem [0:7];
  logic [AW+DW-1:0] exp_wr [$];
  logic [DW-1:0]    exp_rsp [$];
  logic [AW+DW-1:0] wr_e;
  logic [DW-1:0]    rsp_e;
  int exp_done = 0, exp_err = 0, done_seen = 0, err_seen = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  // Per-cycle compare of RAM traffic, responses and pulse widths against the model
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_load) begin
        if (exp_wr.size() == 0) check("unexpected_load", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          wr_e = exp_wr.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(wr_e[AW+DW-1:DW]));
          check("wr_data", 32'(mem_wdata), 32'(wr_e[DW-1:0]));
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
        else begin
          rsp_e = exp_rsp.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(rsp_e));
        end
      end
      if (done) begin done_seen++; check("done_width", 32'(prev_done), 0); end
      if (err)  begin err_seen++;  check("err_width", 32'(prev_err), 0); end
    end
    prev_done = done;
    prev_err  = err;
  end

  // Present one command, wait for acceptance, update the model; returns at the
  // falling edge right after the accepting edge
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic r;
    int n;
    r = 1'b0; n = 0;
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (n < 50) begin
      r = cmd_ready;
      @(posedge clk);
      if (r) break;
      n++;
    end
    check("cmd_accept", 32'(r), 1);
    case (op)
      2'b00: exp_rsp.push_back(model_mem[a]);
      2'b01: begin model_mem[a] = d; exp_wr.push_back({a, d}); exp_done++; end
      2'b10: begin
        for (int i = 0; i < 8; i++) begin
          model_mem[i] = '0;
          exp_wr.push_back({3'(i), 16'h0000});
        end
        exp_done++;
      end
      default: exp_err++;
    endcase
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = ~a;
    cmd_wdata = ~d;
    @(negedge clk);
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send(2'b01, a, d);
    @(negedge clk);
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] got, output int lat);
    send(2'b00, a, 16'h0);
    lat = 0;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    got = rsp_data;
    if (rsp_ready) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got;
    int lat, n, last, loads, dones;
    logic r;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_load", 32'(mem_load), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_cmd_ready", 32'(cmd_ready), 1);

    // Write 0x1234 @5 then read it back
    send(2'b01, 3'd5, 16'h1234);
    check("wr_load", 32'(mem_load), 1);
    check("wr_addr_lit", 32'(mem_addr), 5);
    check("wr_data_lit", 32'(mem_wdata), 32'h1234);
    check("wr_busy", 32'(cmd_ready), 0);
    check("wr_no_done_yet", 32'(done), 0);
    @(negedge clk);
    check("wr_done", 32'(done), 1);
    check("wr_load_off", 32'(mem_load), 0);
    check("wr_ready_back", 32'(cmd_ready), 1);
    @(negedge clk);
    check("wr_done_off", 32'(done), 0);
    read_word(3'd5, got, lat);
    check("rd5_latency", 32'(lat), 2);
    check("rd5_data", 32'(got), 32'h1234);
    check("rd5_released", 32'(rsp_valid), 0);
    check("rd5_ready_back", 32'(cmd_ready), 1);

    // Back-to-back writes with cmd_valid held high
    cmd_op = 2'b01; cmd_addr = 3'd0; cmd_wdata = 16'hA000; cmd_valid = 1'b1;
    n = 0; last = 0;
    for (int i = 0; i < 8 && n < 100; ) begin
      r = cmd_ready;
      @(posedge clk);
      n++;
      if (r) begin
        if (i > 0) check("b2b_spacing", 32'(n - last), 2);
        last = n;
        model_mem[i] = 16'hA000 + 16'(i);
        exp_wr.push_back({3'(i), 16'hA000 + 16'(i)});
        exp_done++;
        i++;
        #1;
        if (i < 8) begin cmd_addr = 3'(i); cmd_wdata = 16'hA000 + 16'(i); end
        else cmd_valid = 1'b0;
      end else begin
        #1;
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      read_word(3'(i), got, lat);
      check("fill_readback", 32'(got), 32'hA000 + 32'(i));
    end

    // Read @2 with the requester stalling
    rsp_ready = 1'b0;
    read_word(3'd2, got, lat);
    check("stall_latency", 32'(lat), 2);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(rsp_valid), 1);
      check("stall_data", 32'(rsp_data), 32'hA002);
      check("stall_busy", 32'(cmd_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_released", 32'(rsp_valid), 0);
    check("stall_ready_back", 32'(cmd_ready), 1);
    check("stall_data_held", 32'(rsp_data), 32'hA002);

    // Clear all
    send(2'b10, 3'd6, 16'h5555);
    loads = 0; dones = 0;
    for (int k = 0; k < 12; k++) begin
      if (mem_load) begin
        check("clr_addr_order", 32'(mem_addr), 32'(loads));
        loads++;
      end
      if (done) dones++;
      @(negedge clk);
    end
    check("clr_load_cycles", 32'(loads), 8);
    check("clr_done_pulses", 32'(dones), 1);
    for (int i = 0; i < 8; i++) begin
      read_word(3'(i), got, lat);
      check("clr_readback", 32'(got), 0);
    end

    // Reserved op
    send(2'b11, 3'd1, 16'hFFFF);
    check("rsv_err", 32'(err), 1);
    check("rsv_no_load", 32'(mem_load), 0);
    check("rsv_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    check("rsv_err_off", 32'(err), 0);

    // Reset during a clear after three RAM writes
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'hC000 + 16'(i));
    send(2'b10, 3'd0, 16'h0);
    check("abort_first_load", 32'(mem_load), 1);
    repeat (3) @(negedge clk);
    check("abort_addr_before", 32'(mem_addr), 3);
    #1 rst_n = 1'b0;
    #1;
    check("abort_load_drop", 32'(mem_load), 0);
    check("abort_ready_drop", 32'(cmd_ready), 0);
    check("abort_done", 32'(done), 0);
    exp_wr.delete();
    exp_done--;
    for (int i = 3; i < 8; i++) model_mem[i] = 16'hC000 + 16'(i);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_back", 32'(cmd_ready), 1);
    check("abort_no_done", 32'(done), 0);
    for (int i = 0; i < 8; i++) begin
      read_word(3'(i), got, lat);
      check("abort_readback", 32'(got), (i < 3) ? 32'h0 : 32'hC000 + 32'(i));
    end

    @(negedge clk);
    check("total_done", 32'(done_seen), 32'(exp_done));
    check("total_err", 32'(err_seen), 32'(exp_err));
    check("wr_queue_empty", 32'(exp_wr.size()), 0);
    check("rsp_queue_empty", 32'(exp_rsp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
